fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage sitting directly upstream of the single-cycle `top` core. It issues sequential word reads to instruction memory, buffers returned words with their PCs in a small FIFO, and presents one instruction per cycle on the `instruction` port `top` consumes. It also handles taken branch/jump redirects from the core by flushing the buffer and discarding stale in-flight data.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: fetch address after reset; word aligned.

- `clk`  in  1  core clock; all logic on rising edge.
- `nrst`  in  1  reset; **one clock; reset is synchronous and active-low**.
- `redirect`  in  1  core took a branch/jump this cycle.
- `redirect_pc`  in  32  target of the redirect.
- `imem_req`  out  1  single-cycle read request.
- `imem_addr`  out  32  word address of the request; valid when `imem_req`=1.
- `imem_ack`  in  1  one-cycle pulse with read data; earliest one cycle after `imem_req`.
- `imem_rdata`  in  32  read data; valid when `imem_ack`=1.
- `instr_valid`  out  1  FIFO head valid.
- `instruction`  out  32  head instruction word; 0 when `instr_valid`=0.
- `instr_pc`  out  32  PC of head word; 0 when `instr_valid`=0.
- `instr_take`  in  1  core consumes head this cycle.
- `fetch_err`  out  1  misaligned-redirect error (see Configuration).

## Operation
- Registers: `fetch_pc` (32), FIFO of DEPTH × {pc, word}, `count` (0..DEPTH), state.
- At most one memory request is outstanding at any time.
- States:
  - FETCH: `imem_req`=1, `imem_addr`=`fetch_pc` when `count`<DEPTH and `redirect`=0. Issuing moves to WAIT. Otherwise stay in FETCH.
  - WAIT: on `imem_ack`, push {`fetch_pc`, `imem_rdata`}, set `fetch_pc`+=4, and go to FETCH.
  - DRAIN: wait for the stale `imem_ack`, discard its data, then go to FETCH.
  - ERROR: only with the macro; see Configuration.
- Redirect has highest priority over push, pop and request. It flushes the FIFO (`count`=0) and loads `fetch_pc`=`redirect_pc`.
  - From WAIT with no ack that cycle: go to DRAIN.
  - From WAIT with ack that same cycle: data is discarded; go to FETCH.
  - From DRAIN: stay in DRAIN and update `fetch_pc`.
  - From FETCH: go to FETCH.
- `instr_take` with `instr_valid`=1 pops the head. `instr_take` with `instr_valid`=0 is ignored. `instr_take` in a redirect cycle is ignored.
- Push and pop in the same cycle leave `count` unchanged. Pop when full plus push in the same cycle is legal.
- `imem_ack` in FETCH state (spurious) is ignored.
- `fetch_pc` increment wraps modulo 2^32: 0xFFFF_FFFC → 0x0000_0000.
- FIFO pointers are log2(DEPTH) bits and wrap naturally.

## Timing
- Reset values (after a rising edge with `nrst`=0):
  - state FETCH, `fetch_pc`=RESET_PC, `count`=0.
  - `imem_req`=0 while `nrst`=0.
  - `instr_valid`=0, `instruction`=0, `instr_pc`=0, `fetch_err`=0.
- Reset mid-operation drops any outstanding request. The memory must not return an ack after reset; any such ack is ignored.
- First `imem_req` goes out in the first cycle with `nrst`=1, for RESET_PC.
- `imem_ack` in cycle N gives `instr_valid`=1 in N+1; next `imem_req` is in N+1 if not full.
- Redirect in cycle N gives `instr_valid`=0 in N+1.
  - Request for `redirect_pc` is in N+1, or in the cycle after the stale ack when draining.
- Maximum throughput is one instruction per two cycles with a 1-cycle memory.

## Configuration
- Macro: `FETCH_MISALIGN_TRAP_EN`.
- Defined:
  - A redirect with `redirect_pc[1:0]`≠0 flushes as normal, then enters ERROR (via DRAIN if a request is outstanding).
  - In ERROR: `fetch_err`=1, no requests, `instr_valid`=0.
  - ERROR exits only on `nrst`=0 or an aligned redirect.
- Undefined:
  - `redirect_pc[1:0]` are forced to 00.
  - `fetch_err` is tied to 0 and there is no ERROR state.

## Test plan
- Reset, RESET_PC=0, memory acks 1 cycle after each req with data = addr ^ 32'h3e800093 → head PCs are 0, 4, 8 in order, each with matching data; first req is in the cycle after `nrst` rises.
- Hold `instr_take`=0 with DEPTH=4 → exactly 4 requests issued, then `imem_req` stays 0. One take → exactly one new request follows.
- Redirect to 0x100 while in WAIT with ack 3 cycles later → that ack's data is never presented. Next req addr is 0x100 and next `instr_pc` is 0x100.
- Redirect to 0x200 in the same cycle as `imem_ack` and `instr_take` → FIFO empty next cycle, req for 0x200 that cycle, and stale data dropped.
- Redirect to 0xFFFF_FFF8 → requests go 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- With the macro: redirect to 0x102 → `fetch_err`=1, no requests; then aligned redirect to 0x104 → `fetch_err`=0 and req for 0x104. Without the macro, the same stimulus gives a req for 0x100.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential word reads into a small {pc, word} FIFO, with redirect flush.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  input  logic        instr_take,
  output logic        fetch_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DRAIN, S_ERROR} state_t;
`else
  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DRAIN} state_t;
`endif

  state_t             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [31:0]        fifo_pc_q   [DEPTH];
  logic [31:0]        fifo_word_q [DEPTH];

  logic        push, pop, head_valid, can_req, misalign;
  logic [31:0] redir_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic err_pend_q, err_pend_d;
  assign redir_pc  = redirect_pc;
  assign misalign  = |redirect_pc[1:0];
  assign fetch_err = (state_q == S_ERROR);
  assign head_valid = (count_q != '0) && (state_q != S_ERROR);
`else
  assign redir_pc  = redirect_pc & 32'hFFFF_FFFC;
  assign misalign  = 1'b0;
  assign fetch_err = 1'b0;
  assign head_valid = (count_q != '0);
`endif

  assign can_req     = nrst && !redirect && (state_q == S_FETCH) && (count_q < DEPTH_C);
  assign imem_req    = can_req;
  assign imem_addr   = fetch_pc_q;
  assign instr_valid = head_valid;
  assign instruction = head_valid ? fifo_word_q[rd_ptr_q] : 32'h0;
  assign instr_pc    = head_valid ? fifo_pc_q[rd_ptr_q]   : 32'h0;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    push       = 1'b0;
    pop        = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    err_pend_d = err_pend_q;
`endif
    if (redirect) begin
      // Flush wins over everything; an in-flight request is drained unless it lands now.
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fetch_pc_d = redir_pc;
      if ((state_q == S_WAIT || state_q == S_DRAIN) && !imem_ack)
        state_d = S_DRAIN;
      else
        state_d = S_FETCH;
`ifdef FETCH_MISALIGN_TRAP_EN
      err_pend_d = misalign;
      if (misalign && state_d == S_FETCH)
        state_d = S_ERROR;
`endif
    end else begin
      pop = instr_take && head_valid;
      case (state_q)
        S_FETCH: if (can_req) state_d = S_WAIT;
        S_WAIT: begin
          if (imem_ack) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = S_FETCH;
          end
        end
        S_DRAIN: begin
          if (imem_ack) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            state_d = err_pend_q ? S_ERROR : S_FETCH;
`else
            state_d = S_FETCH;
`endif
          end
        end
        default: state_d = state_q;
      endcase
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q    <= S_FETCH;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (!nrst) err_pend_q <= 1'b0;
    else       err_pend_q <= err_pend_d;
  end
`endif

  // Storage carries no reset; validity is tracked solely by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]   <= fetch_pc_q;
      fifo_word_q[wr_ptr_q] <= imem_rdata;
    end
  end

endmodule
